// File: rtl/config_pkg.sv
// Core-wide configuration shared by the writeback slice: data width,
// register file geometry and the writeback source encoding.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } core_conf_t;

    localparam core_conf_t DEFAULT_CONF = '{XLEN: 32};

    localparam int NUM_ARCH_REGS  = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int PEND_W_DEFAULT = 2;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/core_wb_scoreboard.sv
// Per-register pending-write counters; x0 is never tracked.
// busy/issue_ready/err_underflow are derived from the registered counters.
module core_wb_scoreboard
    import config_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  issue_ready,
    output logic [NUM_ARCH_REGS-1:0] busy,
    output logic                  err_underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q [NUM_ARCH_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_ARCH_REGS];
    logic              inc;

    always_comb begin
        issue_ready   = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);
        inc           = issue_valid && issue_ready && (issue_rd != '0);
        err_underflow = wb_we && (cnt_q[wb_addr] == '0);
    end

    // A writeback to an empty counter is an error, not a decrement.
    always_comb begin
        logic inc_r;
        logic dec_r;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_r    = inc && (issue_rd == REG_ADDR_W'(r));
            dec_r    = wb_we && (wb_addr == REG_ADDR_W'(r)) && (cnt_q[r] != '0);
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_r && !inc_r) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

endmodule

// File: rtl/core_wb_unit.sv
// Writeback driver: round-robin arbitration of ALU and LSU results onto a
// registered register-file write port, plus the pending-write scoreboard.
module core_wb_unit
    import config_pkg::*;
#(
    parameter core_conf_t CONF   = DEFAULT_CONF,
    parameter int         PEND_W = PEND_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [REG_ADDR_W-1:0]    alu_rd,
    input  logic [CONF.XLEN-1:0]     alu_data,
    output logic                     alu_ready,
    input  logic                     lsu_valid,
    input  logic [REG_ADDR_W-1:0]    lsu_rd,
    input  logic [CONF.XLEN-1:0]     lsu_data,
    output logic                     lsu_ready,
    input  logic                     issue_valid,
    input  logic [REG_ADDR_W-1:0]    issue_rd,
    output logic                     issue_ready,
    output logic [NUM_ARCH_REGS-1:0] busy,
    output logic [REG_ADDR_W-1:0]    wb_addr,
    output logic [CONF.XLEN-1:0]     wb_data,
    output logic                     wb_we,
    output logic                     err_underflow
);

    wb_src_e                 rr_q, rr_d;
    logic                    grant_alu, grant_lsu;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic [CONF.XLEN-1:0]    sel_data;
    logic                    wr_d;
    logic                    wb_we_q;
    logic [REG_ADDR_W-1:0]   wb_addr_q;
    logic [CONF.XLEN-1:0]    wb_data_q;

    // The pointer only moves on contention, so a lone source never
    // steals priority from the other.
    always_comb begin
        grant_alu = alu_valid && (!lsu_valid || (rr_q == WB_SRC_ALU));
        grant_lsu = lsu_valid && (!alu_valid || (rr_q == WB_SRC_LSU));
        rr_d      = rr_q;
        if (alu_valid && lsu_valid) begin
            rr_d = (rr_q == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
        end
        sel_rd   = grant_lsu ? lsu_rd   : alu_rd;
        sel_data = grant_lsu ? lsu_data : alu_data;
        wr_d     = (grant_alu || grant_lsu) && (sel_rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= WB_SRC_ALU;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wb_we_q <= wr_d;
            if (wr_d) begin
                wb_addr_q <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

    core_wb_scoreboard #(
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .wb_we         (wb_we_q),
        .wb_addr       (wb_addr_q),
        .issue_ready   (issue_ready),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

endmodule

// File: tb/tb_core_wb_unit.sv
// Self-checking bench for core_wb_unit: directed scenarios followed by
// random traffic, all compared against a per-register pending-count model.
module tb_core_wb_unit;
    import config_pkg::*;

    localparam int XLEN   = DEFAULT_CONF.XLEN;
    localparam int PEND_W = PEND_W_DEFAULT;
    localparam int MAXCNT = (1 << PEND_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]      alu_rd = '0, lsu_rd = '0, issue_rd = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic            alu_ready, lsu_ready, issue_ready, wb_we, err_underflow;
    logic [31:0]     busy;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    core_wb_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .busy(busy), .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: outstanding writes per register, the write expected
    // on the port this cycle, and which source has priority on contention.
    int              pend [32];
    bit              m_we;
    int              m_addr;
    logic [XLEN-1:0] m_data;
    bit              m_pref_lsu;
    bit              last_ga, last_gl;
    bit              obs_alu_rdy;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_we = 0; m_addr = 0; m_data = '0; m_pref_lsu = 0;
        last_ga = 0; last_gl = 0;
    endtask

    // Inputs are already applied; check at the falling edge, advance the
    // model, then return 1 ns after the rising edge.
    task automatic cycle();
        bit ga, gl, ir_ok, und;
        logic [31:0] bz;
        @(negedge clk);
        ga    = alu_valid && (!lsu_valid || !m_pref_lsu);
        gl    = lsu_valid && (!alu_valid ||  m_pref_lsu);
        ir_ok = (issue_rd == 0) || (pend[issue_rd] < MAXCNT);
        bz = '0;
        for (int i = 1; i < 32; i++) bz[i] = (pend[i] != 0);
        und = m_we && (pend[m_addr] == 0);
        obs_alu_rdy = alu_ready;
        check("alu_ready", alu_ready, ga);
        check("lsu_ready", lsu_ready, gl);
        check("issue_ready", issue_ready, ir_ok);
        check("busy", busy, bz);
        check("wb_we", wb_we, m_we);
        check("err_underflow", err_underflow, und);
        if (m_we) begin
            check("wb_addr", wb_addr, m_addr);
            check("wb_data", wb_data, m_data);
        end
        if (m_we && pend[m_addr] > 0) pend[m_addr]--;
        if (issue_valid && ir_ok && issue_rd != 0) pend[issue_rd]++;
        m_we = 0;
        if (ga && alu_rd != 0) begin m_we = 1; m_addr = alu_rd; m_data = alu_data; end
        if (gl && lsu_rd != 0) begin m_we = 1; m_addr = lsu_rd; m_data = lsu_data; end
        if (alu_valid && lsu_valid) m_pref_lsu = !m_pref_lsu;
        last_ga = ga; last_gl = gl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    endtask

    initial begin
        bit exp_alu;
        model_reset();
        #12;
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_busy", busy, 32'h0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_lsu_ready", lsu_ready, 1'b0);
        check("rst_err", err_underflow, 1'b0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        repeat (2) cycle();

        // Single issue and ALU writeback to x5.
        issue_valid = 1; issue_rd = 5;
        cycle();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 0;
        check("x5_we", wb_we, 1'b1);
        check("x5_addr", wb_addr, 5);
        check("x5_data", wb_data, 32'hDEADBEEF);
        check("x5_busy_set", busy[5], 1'b1);
        cycle();
        check("x5_busy_clr", busy[5], 1'b0);

        // Contention: both sources valid for four cycles.
        issue_valid = 1;
        issue_rd = 3; cycle(); cycle();
        issue_rd = 4; cycle(); cycle();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 3; lsu_valid = 1; lsu_rd = 4;
        for (int k = 0; k < 4; k++) begin
            alu_data = 32'hA000 + k; lsu_data = 32'hB000 + k;
            exp_alu = (k % 2 == 0);
            cycle();
            check("rr_alu_grant", obs_alu_rdy, exp_alu);
        end
        idle_inputs();
        cycle(); cycle();
        check("rr_busy3", busy[3], 1'b0);
        check("rr_busy4", busy[4], 1'b0);

        // Saturate x7, then writeback concurrent with issue.
        issue_valid = 1; issue_rd = 7;
        repeat (4) cycle();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        cycle();
        alu_valid = 0; issue_valid = 1; issue_rd = 7;
        cycle();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        cycle();
        alu_valid = 0; issue_valid = 1; issue_rd = 7;
        cycle();
        issue_valid = 0;
        cycle();

        // x0 result and an underflowing write to x9.
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        cycle();
        lsu_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        cycle();
        alu_valid = 0;
        cycle(); cycle();

        // Reset while a write is in flight.
        issue_valid = 1; issue_rd = 2;
        cycle();
        issue_valid = 0; alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        cycle();
        alu_valid = 0;
        check("pre_rst_we", wb_we, 1'b1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_we", wb_we, 1'b0);
        check("mid_rst_busy", busy, 32'h0);
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        repeat (3) cycle();

        // Random traffic; an unaccepted source keeps its request stable.
        for (int c = 0; c < 500; c++) begin
            if (!(alu_valid && !last_ga)) begin
                alu_valid = $urandom_range(0, 1);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !last_gl)) begin
                lsu_valid = $urandom_range(0, 1);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
